alu_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one registered ALU instance between clients.
- Each client uses a valid/ready request channel and a valid/ready response channel.
- The block drives the ALU operand and control lines, waits out the ALU pipeline latency, and captures the result.
- It derives the zero flag from the captured result itself, not from the ALU's zero output, which lags by one cycle.
- One operation is outstanding at a time. The block sits between the decode/issue logic and the shared ALU.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/rr_arbiter2.sv | 68 ++++++
 rtl/alu_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice:
//   - ALU control codes for the four operations the shared ALU implements
//   - the arbiter FSM state encoding
//   - a helper that tells whether a control code is one the ALU supports
// No ports; imported by alu_arbiter and anything that needs the op codes.
// ---------------------------------------------------------------------------
package alu_pkg;

  // ALU control codes. Anything not listed here is rejected by the arbiter
  // without ever reaching the ALU.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // Arbiter FSM states.
  //   IDLE : waiting for a request, grant logic active
  //   EXEC : operands on the ALU, waiting out the pipeline latency
  //   CAPT : ALU result is valid this cycle and gets captured
  //   RESP : response presented to the owner until it is accepted
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

  // True when the control code is one of the supported ALU operations.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR) ||
           (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant. The grant is purely combinational from the two
// valids and the registered last_grant; last_grant only moves when the
// parent reports that a grant was actually taken (accept strobe).
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   enable          grants allowed this cycle (parent is idle)
//   valid0, valid1  request valids from client 0 / client 1
//   accept          a granted request handshook at this edge
//   grant0, grant1  one-hot grant (both low when disabled or no request)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant0,
  output logic grant1
);

  // last_grant_q holds the index of the client served most recently.
  // It resets to 1 so that client 0 wins the very first tie.
  logic last_grant_q;
  logic last_grant_d;

  // Grant selection. A lone requester always wins; on a tie the client
  // that was not served last wins, which gives strict alternation under
  // continuous contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (enable) begin
      if (valid0 && valid1) begin
        if (last_grant_q) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (valid0) begin
        grant0 = 1'b1;
      end else if (valid1) begin
        grant1 = 1'b1;
      end
    end
  end

  // The winner of an accepted grant becomes the new last_grant. Only one of
  // the grants can be high, so grant1 alone identifies the winner.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one registered ALU between two clients. Each client issues an
// operation on a valid/ready request channel and receives the result on a
// valid/ready response channel. Only one operation is in flight at a time.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/ready           client N request handshake
//   reqN_a, reqN_b, reqN_op    client N operands and ALU control code
//   rspN_valid/ready           client N response handshake
//   rspN_result/zero/err       captured result, result==0, illegal op
//   alu_a, alu_b, alu_control  drive to the shared ALU
//   alu_result                 result from the shared ALU
//   busy                       an operation is in flight (not IDLE)
//
// The zero flag is computed here from the captured result because the ALU's
// own zero output arrives one cycle after its result.
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,

  output logic             busy
);

  // The latency counter only needs to reach ALU_LATENCY-1; keep it at least
  // one bit wide so the single-cycle ALU case still has a legal vector.
  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LATENCY - 1);

  state_e           state_q,   state_d;
  logic             owner_q,   owner_d;
  logic [2:0]       op_q,      op_d;
  logic [WIDTH-1:0] alu_a_q,   alu_a_d;
  logic [WIDTH-1:0] alu_b_q,   alu_b_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             zero_q,    zero_d;
  logic             err_q,     err_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic             grant0;
  logic             grant1;
  logic             handshake;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;
  logic             owner_rsp_ready;

  // Grants are only offered in IDLE, so a client can never be handed the
  // ALU while another operation or an unaccepted response is pending.
  rr_arbiter2 u_rr_arbiter2 (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == IDLE),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .accept (handshake),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Grants already imply the matching valid, the AND just makes the
  // handshake definition explicit.
  assign handshake = (req0_valid && grant0) || (req1_valid && grant1);

  // Payload of whichever client is being granted this cycle.
  always_comb begin
    sel_a  = req0_a;
    sel_b  = req0_b;
    sel_op = req0_op;
    if (grant1) begin
      sel_a  = req1_a;
      sel_b  = req1_b;
      sel_op = req1_op;
    end
  end

  // Only the owner's response ready can retire the response; the other
  // client's ready is don't-care.
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state logic. Operands go straight into the ALU drive registers on
  // a legal handshake, so they are on the ALU from the first EXEC cycle and
  // stay there until the next legal operation. An illegal op never touches
  // the ALU registers and jumps directly to RESP with a fixed error reply.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_d      = op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    result_d  = result_q;
    zero_d    = zero_q;
    err_d     = err_q;
    lat_cnt_d = lat_cnt_q;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          owner_d = grant1;
          op_d    = sel_op;
          if (is_legal_op(sel_op)) begin
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            lat_cnt_d = '0;
            state_d   = EXEC;
          end else begin
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end

      // Hold the ALU inputs for exactly ALU_LATENCY cycles.
      EXEC: begin
        if (lat_cnt_q == LAST_CNT) begin
          lat_cnt_d = '0;
          state_d   = CAPT;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      // alu_result is valid this cycle; the zero flag is derived here
      // rather than taken from the ALU, whose flag is a cycle late.
      CAPT: begin
        result_d = alu_result;
        zero_d   = (alu_result == '0);
        err_d    = 1'b0;
        state_d  = RESP;
      end

      RESP: begin
        if (owner_rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any operation in flight;
  // no response is ever produced for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      op_q      <= ALU_AND;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // The control code is only presented while executing; at all other times
  // the ALU sees AND (000) on whatever operands it last had.
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = (state_q == EXEC) ? op_q : ALU_AND;

  // Both clients see the same result registers; only the owner's valid is
  // raised, so the other client never consumes them.
  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) &&  owner_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. A behavioural ALU with ALU_LATENCY
// register stages stands in for the shared ALU. Expected grants, results,
// flags and response timing come from a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int W   = 32;
  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_control;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int model_last = 1;

  logic [2:0]   p_op [2];
  logic [W-1:0] p_a  [2];
  logic [W-1:0] p_b  [2];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
    .busy(busy)
  );

  // Reference arithmetic for the four supported ops, wrap-around width.
  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b110);
  endfunction

  // Round-robin: lone requester wins, ties go to whoever was not served last.
  function automatic int ref_winner(input bit v0, input bit v1, input int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Behavioural shared ALU: result appears LAT edges after operands.
  logic [W-1:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= ref_result(alu_control, alu_a, alu_b);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[LAT-1];

  task automatic set_req(input int who, input bit v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    p_op[who] = op; p_a[who] = a; p_b[who] = b;
    if (who == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    else          begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_last = 1;
    #1;
  endtask

  // Drives one granted transaction to completion: handshake, drop valid,
  // wait for the response, stall `stall` cycles, accept. Returns observations.
  // Precondition: just after a negedge with `who` currently granted.
  task automatic run_txn(input int who, input int stall, output int lat, output logic [W-1:0] res,
                         output logic z, output logic e, output bit other_seen, output bit ctrl_seen,
                         output bit stable_ok, output bit grant_seen);
    bit got;
    got = 0; lat = 0; other_seen = 0; ctrl_seen = 0; stable_ok = 1; grant_seen = 0;
    @(posedge clk);
    @(negedge clk);
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    while (!got && lat < 50) begin
      lat++;
      if (alu_control !== 3'b000) ctrl_seen = 1;
      if ((who == 0 ? rsp1_valid : rsp0_valid) !== 1'b0) other_seen = 1;
      if ((who == 0 ? rsp0_valid : rsp1_valid) === 1'b1) got = 1;
      else begin @(negedge clk); #1; end
    end
    if (!got) lat = -1;
    res = (who == 0) ? rsp0_result : rsp1_result;
    z   = (who == 0) ? rsp0_zero   : rsp1_zero;
    e   = (who == 0) ? rsp0_err    : rsp1_err;
    repeat (stall) begin
      @(negedge clk); #1;
      if ((who == 0 ? rsp0_valid : rsp1_valid) !== 1'b1) stable_ok = 0;
      if ((who == 0 ? rsp0_result : rsp1_result) !== res) stable_ok = 0;
      if ((who == 0 ? rsp0_zero : rsp1_zero) !== z || (who == 0 ? rsp0_err : rsp1_err) !== e) stable_ok = 0;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) grant_seen = 1;
    end
    if (who == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); end
    checks++; if ({rsp0_result, rsp0_zero, rsp0_err} !== '0) begin errors++; $display("[TB] FAIL reset_rsp0: got %h/%b/%b expected 0/0/0", rsp0_result, rsp0_zero, rsp0_err); end
    checks++; if ({rsp1_result, rsp1_zero, rsp1_err} !== '0) begin errors++; $display("[TB] FAIL reset_rsp1: got %h/%b/%b expected 0/0/0", rsp1_result, rsp1_zero, rsp1_err); end
    checks++; if ({alu_a, alu_b, alu_control} !== '0) begin errors++; $display("[TB] FAIL reset_alu: got %h/%h/%b expected 0/0/000", alu_a, alu_b, alu_control); end
    reset = 1'b0;
    model_last = 1;
  endtask

  task automatic test_single_add();
    int lat; logic [W-1:0] res; logic z, e; bit os, cs, st, gs;
    $display("[TB] test_single_add");
    @(negedge clk);
    set_req(0, 1, 3'b010, 32'd5, 32'd7);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("[TB] FAIL add_grant: got %b expected 10", {req0_ready, req1_ready}); end
    run_txn(0, 0, lat, res, z, e, os, cs, st, gs);
    model_last = 0;
    checks++; if (lat !== LAT + 2) begin errors++; $display("[TB] FAIL add_latency: got %0d expected %0d", lat, LAT + 2); end
    checks++; if ({res, z, e} !== {32'd12, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL add_result: got %h/%b/%b expected c/0/0", res, z, e); end
    checks++; if (os !== 1'b0) begin errors++; $display("[TB] FAIL add_rsp1_quiet: got %b expected 0", os); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL add_idle_after: got %b expected 0", busy); end
  endtask

  // Both clients request together; the model decides order each round.
  task automatic test_simultaneous();
    int lat, w, l; logic [W-1:0] res, exp_res; logic z, e; bit os, cs, st, gs;
    $display("[TB] test_simultaneous");
    do_reset();
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      if (r == 0) begin
        set_req(0, 1, 3'b110, 32'd9, 32'd9);
        set_req(1, 1, 3'b001, 32'hF0, 32'h0F);
      end else begin
        set_req(0, 1, 3'b010, $urandom, $urandom);
        set_req(1, 1, 3'b000, $urandom, $urandom);
      end
      #1;
      w = ref_winner(1, 1, model_last);
      l = 1 - w;
      checks++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin errors++; $display("[TB] FAIL tie_grant r%0d: got %b%b expected winner %0d", r, req0_ready, req1_ready, w); end
      run_txn(w, 0, lat, res, z, e, os, cs, st, gs);
      model_last = w;
      exp_res = ref_result(p_op[w], p_a[w], p_b[w]);
      checks++; if ({res, z, e} !== {exp_res, exp_res == '0, 1'b0}) begin errors++; $display("[TB] FAIL tie_first r%0d: got %h/%b/%b expected %h/%b/0", r, res, z, e, exp_res, exp_res == '0); end
      checks++; if (req0_ready !== (l == 0) || req1_ready !== (l == 1)) begin errors++; $display("[TB] FAIL tie_loser_grant r%0d: got %b%b expected client %0d", r, req0_ready, req1_ready, l); end
      run_txn(l, 0, lat, res, z, e, os, cs, st, gs);
      model_last = l;
      exp_res = ref_result(p_op[l], p_a[l], p_b[l]);
      checks++; if ({res, z, e} !== {exp_res, exp_res == '0, 1'b0}) begin errors++; $display("[TB] FAIL tie_second r%0d: got %h/%b/%b expected %h/%b/0", r, res, z, e, exp_res, exp_res == '0); end
    end
  endtask

  task automatic test_illegal();
    int lat; logic [W-1:0] res; logic z, e; bit os, cs, st, gs;
    $display("[TB] test_illegal");
    @(negedge clk);
    set_req(1, 1, 3'b111, $urandom, $urandom);
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_grant: got %b expected 1", req1_ready); end
    run_txn(1, 0, lat, res, z, e, os, cs, st, gs);
    model_last = 1;
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL illegal_latency: got %0d expected 1", lat); end
    checks++; if ({res, z, e} !== {32'd0, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL illegal_rsp: got %h/%b/%b expected 0/1/1", res, z, e); end
    checks++; if (cs !== 1'b0) begin errors++; $display("[TB] FAIL illegal_alu_ctrl: got %b expected 0", cs); end
    checks++; if (os !== 1'b0) begin errors++; $display("[TB] FAIL illegal_rsp0_quiet: got %b expected 0", os); end
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] res, exp_res; logic z, e; bit os, cs, st, gs;
    $display("[TB] test_backpressure");
    do_reset();
    @(negedge clk);
    set_req(0, 1, 3'b000, 32'hFF00FF00, 32'h0FF00FF0);
    set_req(1, 1, 3'b010, 32'd100, 32'd23);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("[TB] FAIL bp_grant: got %b expected 10", {req0_ready, req1_ready}); end
    run_txn(0, 5, lat, res, z, e, os, cs, st, gs);
    model_last = 0;
    checks++; if (res !== 32'h0F000F00) begin errors++; $display("[TB] FAIL bp_result: got %h expected 0f000f00", res); end
    checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL bp_stable: got %b expected 1", st); end
    checks++; if (gs !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_grant: got %b expected 0", gs); end
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("[TB] FAIL bp_next_grant: got %b expected 01", {req0_ready, req1_ready}); end
    run_txn(1, 0, lat, res, z, e, os, cs, st, gs);
    model_last = 1;
    exp_res = 32'd123;
    checks++; if ({res, z, e} !== {exp_res, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL bp_second: got %h/%b/%b expected 7b/0/0", res, z, e); end
  endtask

  task automatic test_wrap();
    int lat; logic [W-1:0] res; logic z, e; bit os, cs, st, gs;
    $display("[TB] test_wrap");
    @(negedge clk);
    set_req(0, 1, 3'b110, 32'd0, 32'd1);
    #1;
    run_txn(0, 1, lat, res, z, e, os, cs, st, gs);
    model_last = 0;
    checks++; if ({res, z, e} !== {32'hFFFFFFFF, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL wrap_sub: got %h/%b/%b expected ffffffff/0/0", res, z, e); end
    @(negedge clk);
    set_req(0, 1, 3'b010, 32'hFFFFFFFF, 32'd1);
    #1;
    run_txn(0, 0, lat, res, z, e, os, cs, st, gs);
    checks++; if ({res, z, e} !== {32'd0, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL wrap_add: got %h/%b/%b expected 0/1/0", res, z, e); end
  endtask

  task automatic test_reset_midop();
    int lat, seen, w; logic [W-1:0] res, exp_res; logic z, e; bit os, cs, st, gs;
    $display("[TB] test_reset_midop");
    @(negedge clk);
    set_req(0, 1, 3'b010, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midop_busy: got %b expected 1", busy); end
    @(negedge clk);
    reset = 1'b0;
    model_last = 1;
    #1;
    checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("[TB] FAIL midop_discard: got %b expected 000", {busy, rsp0_valid, rsp1_valid}); end
    checks++; if ({alu_a, alu_b, alu_control} !== '0) begin errors++; $display("[TB] FAIL midop_alu_reset: got %h/%h/%b expected 0/0/000", alu_a, alu_b, alu_control); end
    seen = 0;
    repeat (4) begin @(negedge clk); #1; if (rsp0_valid || rsp1_valid || busy) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midop_quiet: got %0d active cycles expected 0", seen); end
    @(negedge clk);
    set_req(0, 1, 3'b001, 32'h1, 32'h2);
    set_req(1, 1, 3'b010, 32'd40, 32'd2);
    #1;
    w = ref_winner(1, 1, model_last);
    checks++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin errors++; $display("[TB] FAIL midop_tie: got %b%b expected winner %0d", req0_ready, req1_ready, w); end
    run_txn(w, 0, lat, res, z, e, os, cs, st, gs);
    model_last = w;
    exp_res = ref_result(p_op[w], p_a[w], p_b[w]);
    checks++; if (res !== exp_res) begin errors++; $display("[TB] FAIL midop_first: got %h expected %h", res, exp_res); end
    run_txn(1 - w, 0, lat, res, z, e, os, cs, st, gs);
    model_last = 1 - w;
    exp_res = ref_result(p_op[1-w], p_a[1-w], p_b[1-w]);
    checks++; if (res !== exp_res) begin errors++; $display("[TB] FAIL midop_second: got %h expected %h", res, exp_res); end
  endtask

  // Random mix of requesters, op codes (legal and illegal), operands and
  // response stalls, all compared against the reference model.
  task automatic test_random();
    int lat, w, n; logic [W-1:0] res, exp_res; logic z, e, exp_z, exp_e; bit os, cs, st, gs;
    bit v[2]; logic [2:0] op; logic [W-1:0] a, b;
    $display("[TB] test_random");
    for (int it = 0; it < 40; it++) begin
      v[0] = 1'($urandom_range(0, 1));
      v[1] = 1'($urandom_range(0, 1));
      if (!v[0] && !v[1]) v[$urandom_range(0, 1)] = 1;
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        op = 3'($urandom_range(0, 7));
        a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
        b  = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
        if ($urandom_range(0, 5) == 0) b = a;
        set_req(c, v[c], op, a, b);
      end
      #1;
      n = v[0] + v[1];
      for (int k = 0; k < n; k++) begin
        w = ref_winner(v[0], v[1], model_last);
        checks++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin errors++; $display("[TB] FAIL rand_grant it%0d: got %b%b expected winner %0d", it, req0_ready, req1_ready, w); end
        run_txn(w, $urandom_range(0, 3), lat, res, z, e, os, cs, st, gs);
        v[w] = 0;
        model_last = w;
        if (ref_legal(p_op[w])) begin
          exp_res = ref_result(p_op[w], p_a[w], p_b[w]); exp_z = (exp_res == '0); exp_e = 0;
        end else begin
          exp_res = '0; exp_z = 1; exp_e = 1;
        end
        checks++; if (lat !== (ref_legal(p_op[w]) ? LAT + 2 : 1)) begin errors++; $display("[TB] FAIL rand_latency it%0d: got %0d op %b", it, lat, p_op[w]); end
        checks++; if ({res, z, e} !== {exp_res, exp_z, exp_e}) begin errors++; $display("[TB] FAIL rand_rsp it%0d: got %h/%b/%b expected %h/%b/%b", it, res, z, e, exp_res, exp_z, exp_e); end
        checks++; if (st !== 1'b1 || os !== 1'b0) begin errors++; $display("[TB] FAIL rand_channel it%0d: stable %b other %b expected 1 0", it, st, os); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting alu_arbiter bench");
    test_reset();
    test_single_add();
    test_simultaneous();
    test_illegal();
    test_backpressure();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
